// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bundle: raw keyboard lines in, decoded scan code and status out.
interface ps2_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ps2_info;
  logic       ps2_enable;
  logic       frame_error;
  logic       busy;

  // Receiver side: samples the keyboard lines and produces the decoded byte.
  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ps2_info,
    output ps2_enable,
    output frame_error,
    output busy
  );

  // Keyboard/consumer side: drives the lines and observes the decoded byte.
  modport master (
    output ps2_clk,
    output ps2_data,
    input  ps2_info,
    input  ps2_enable,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes the raw lines, decodes 11-bit frames,
// checks odd parity and stop bit, filters break/extended prefixes and
// abandons stalled frames after TIMEOUT system clocks.
//
// state  | meaning
// IDLE   | waiting for a start bit (data 0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | next edge carries the parity bit
// STOP   | next edge carries the stop bit; frame is judged here
module ps2_receiver #(
  parameter int TIMEOUT      = 50000,
  parameter bit FILTER_BREAK = 1'b1
) (
  input logic           clock,
  input logic           reset,
  ps2_receiver_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic          break_pending;
  logic [CW-1:0] timeout_cnt;
  logic          fall;
  logic          frame_ok;

  assign fall     = clk_prev & ~clk_s2;
  assign frame_ok = (^{shift, parity_bit}) & data_s2;
  assign bus.busy = (state != IDLE);

  // Two-flop synchronizers plus previous-clock register; lines idle high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= bus.ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= bus.ps2_data;
      data_s2  <= data_s1;
    end
  end

  // Frame decoder, break filter and stall timeout with registered strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      shift           <= 8'h00;
      bit_cnt         <= 3'd0;
      parity_bit      <= 1'b0;
      break_pending   <= 1'b0;
      timeout_cnt     <= '0;
      bus.ps2_info    <= 8'h00;
      bus.ps2_enable  <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      bus.ps2_enable  <= 1'b0;
      bus.frame_error <= 1'b0;

      if (state == IDLE) begin
        timeout_cnt <= '0;
        if (fall && !data_s2) begin
          state   <= DATA;
          bit_cnt <= 3'd0;
        end
      end else if (fall) begin
        timeout_cnt <= '0;
        case (state)
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_s2;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              bus.frame_error <= 1'b1;
            end else if (!FILTER_BREAK) begin
              bus.ps2_info   <= shift;
              bus.ps2_enable <= 1'b1;
            end else if (shift == 8'hE0) begin
              // extended prefix carries no key information on its own
            end else if (shift == 8'hF0) begin
              break_pending <= 1'b1;
            end else if (break_pending) begin
              break_pending <= 1'b0;
            end else begin
              bus.ps2_info   <= shift;
              bus.ps2_enable <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout_cnt == TIMEOUT_LAST) begin
        state           <= IDLE;
        shift           <= 8'h00;
        bit_cnt         <= 3'd0;
        timeout_cnt     <= '0;
        bus.frame_error <= 1'b1;
      end else begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: drives PS/2 frames with a 40-cycle
// half-period and checks decoded bytes, strobes, errors, timeout and reset.
module tb_ps2_receiver;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   en_seen;
  int   err_seen;
  int   overlap_seen;
  logic [7:0] last_info;
  logic prev_en, prev_err;

  ps2_receiver_if bus ();

  ps2_receiver #(.TIMEOUT(200), .FILTER_BREAK(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe monitor sampled on the falling system edge.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.ps2_enable) begin
        en_seen   <= en_seen + 1;
        last_info <= bus.ps2_info;
      end
      if (bus.frame_error) err_seen <= err_seen + 1;
      if ((bus.ps2_enable && bus.frame_error) ||
          (bus.ps2_enable && prev_err) || (bus.frame_error && prev_en))
        overlap_seen <= overlap_seen + 1;
    end
    prev_en  <= bus.ps2_enable;
    prev_err <= bus.frame_error;
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Send the first n bits of a frame {stop, parity, data, start}.
  task automatic send_bits(input logic [7:0] d, input logic par, input logic stp, input int n);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      repeat (20) @(negedge clock);
      bus.ps2_clk = 1'b0;
      repeat (40) @(negedge clock);
      bus.ps2_clk = 1'b1;
      repeat (20) @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bits(d, par, stp, 11);
    bus.ps2_data = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (bus.ps2_info !== 8'h00) begin bad++; $display("FAIL reset_info got=%h want=00", bus.ps2_info); end
    total++; if (bus.ps2_enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b want=0", bus.ps2_enable); end
    total++; if (bus.frame_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", bus.frame_error); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    reset = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_single;
    int e0, r0;
    e0 = en_seen; r0 = err_seen;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (en_seen - e0 !== 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h1C) begin bad++; $display("FAIL single_info got=%h want=1c", bus.ps2_info); end
    total++; if (err_seen - r0 !== 0) begin bad++; $display("FAIL single_err got=%0d want=0", err_seen - r0); end
  endtask

  task automatic test_back_to_back;
    int e0;
    e0 = en_seen;
    send_frame(8'h21, 1'b1, 1'b1);
    total++; if (en_seen - e0 !== 1) begin bad++; $display("FAIL b2b_first_pulses got=%0d want=1", en_seen - e0); end
    total++; if (last_info !== 8'h21) begin bad++; $display("FAIL b2b_first_info got=%h want=21", last_info); end
    send_frame(8'h22, 1'b1, 1'b1);
    total++; if (en_seen - e0 !== 2) begin bad++; $display("FAIL b2b_second_pulses got=%0d want=2", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h22) begin bad++; $display("FAIL b2b_second_info got=%h want=22", bus.ps2_info); end
  endtask

  task automatic test_break;
    int e0;
    e0 = en_seen;
    send_frame(8'hE0, odd_par(8'hE0), 1'b1);
    total++; if (en_seen - e0 !== 0) begin bad++; $display("FAIL e0_pulses got=%0d want=0", en_seen - e0); end
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    total++; if (en_seen - e0 !== 0) begin bad++; $display("FAIL break_pulses got=%0d want=0", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h22) begin bad++; $display("FAIL break_info got=%h want=22", bus.ps2_info); end
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    total++; if (en_seen - e0 !== 1) begin bad++; $display("FAIL after_break_pulses got=%0d want=1", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h1C) begin bad++; $display("FAIL after_break_info got=%h want=1c", bus.ps2_info); end
  endtask

  task automatic test_bad_frames;
    int e0, r0;
    send_frame(8'h21, 1'b1, 1'b1);
    e0 = en_seen; r0 = err_seen;
    send_frame(8'h1C, 1'b1, 1'b1);
    total++; if (err_seen - r0 !== 1) begin bad++; $display("FAIL parity_err got=%0d want=1", err_seen - r0); end
    total++; if (en_seen - e0 !== 0) begin bad++; $display("FAIL parity_pulses got=%0d want=0", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h21) begin bad++; $display("FAIL parity_info got=%h want=21", bus.ps2_info); end
    send_frame(8'h1C, 1'b0, 1'b0);
    total++; if (err_seen - r0 !== 2) begin bad++; $display("FAIL stop_err got=%0d want=2", err_seen - r0); end
    total++; if (en_seen - e0 !== 0) begin bad++; $display("FAIL stop_pulses got=%0d want=0", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h21) begin bad++; $display("FAIL stop_info got=%h want=21", bus.ps2_info); end
  endtask

  task automatic test_timeout;
    int r0, e0, waited;
    r0 = err_seen;
    send_bits(8'h05, 1'b1, 1'b1, 5);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_mid got=%b want=1", bus.busy); end
    waited = 0;
    while (err_seen == r0 && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    total++; if (err_seen - r0 !== 1) begin bad++; $display("FAIL timeout_err got=%0d want=1 waited=%0d", err_seen - r0, waited); end
    @(negedge clock);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy_after got=%b want=0", bus.busy); end
    bus.ps2_data = 1'b1;
    repeat (20) @(negedge clock);
    e0 = en_seen;
    send_frame(8'h21, 1'b1, 1'b1);
    total++; if (en_seen - e0 !== 1) begin bad++; $display("FAIL timeout_next_pulses got=%0d want=1", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h21) begin bad++; $display("FAIL timeout_next_info got=%h want=21", bus.ps2_info); end
  endtask

  task automatic test_midframe_reset;
    int e0, r0;
    e0 = en_seen; r0 = err_seen;
    send_bits(8'h1C, 1'b0, 1'b1, 6);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", bus.busy); end
    #2 reset = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy_reset got=%b want=0", bus.busy); end
    total++; if (bus.ps2_info !== 8'h00) begin bad++; $display("FAIL mid_info_reset got=%h want=00", bus.ps2_info); end
    bus.ps2_data = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    total++; if ((en_seen - e0) + (err_seen - r0) !== 0) begin bad++; $display("FAIL mid_no_strobe got=%0d want=0", (en_seen - e0) + (err_seen - r0)); end
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (en_seen - e0 !== 1) begin bad++; $display("FAIL mid_next_pulses got=%0d want=1", en_seen - e0); end
    total++; if (bus.ps2_info !== 8'h1C) begin bad++; $display("FAIL mid_next_info got=%h want=1c", bus.ps2_info); end
  endtask

  initial begin
    total = 0; bad = 0;
    en_seen = 0; err_seen = 0; overlap_seen = 0;
    last_info = 8'h00; prev_en = 1'b0; prev_err = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    #3;
    test_reset();
    test_single();
    test_back_to_back();
    test_break();
    test_bad_frames();
    test_timeout();
    test_midframe_reset();
    total++; if (overlap_seen !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", overlap_seen); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter: TIMEOUT, default 50000, clock cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-002 Parameter: FILTER_BREAK, default 1, when 1 suppresses break (F0-prefixed) codes and E0 prefixes.
REQ-003 clock  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw keyboard clock, asynchronous to clock.
REQ-006 ps2_data  input  1  raw keyboard data, asynchronous to clock.
REQ-007 ps2_info  output  8  last accepted scan code, held between frames; feeds the downstream character-data stage's ps2_info input.
REQ-008 ps2_enable  output  1  one-cycle strobe marking a new ps2_info; feeds the downstream character-data stage's ps2_enable input.
REQ-009 frame_error  output  1  one-cycle strobe on a rejected or timed-out frame.
REQ-010 busy  output  1  high while state is not IDLE.

Function
REQ-011 Synchronize ps2_clk and ps2_data each through two flip-flops; a third register holds the previous synchronized ps2_clk.
REQ-012 Falling edge = previous synchronized clk 1 and current synchronized clk 0; data sampled from synchronized ps2_data in that same cycle.
REQ-013 Frame: start (0), 8 data bits LSB first, odd parity, stop (1); 11 falling edges.
REQ-014 States: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on an edge with data 0 -> DATA with bit count 0; on an edge with data 1 -> stay IDLE, no error.
REQ-016 DATA: each edge shifts the bit into shift[7] (right shift); after the 8th bit -> PARITY.
REQ-017 PARITY: the edge captures the parity bit -> STOP.
REQ-018 STOP: the edge captures the stop bit -> IDLE; the frame is valid iff the popcount of data plus parity is odd and stop = 1.
REQ-019 Valid frame: ps2_info <= byte and ps2_enable = 1 for exactly the one cycle after the stop-edge cycle, unless suppressed by the filter rules below.
REQ-020 Invalid frame: frame_error = 1 for one cycle, with the same timing as ps2_enable; ps2_info unchanged.
REQ-021 With FILTER_BREAK = 1, valid byte F0: set break_pending, no strobe.
REQ-022 With FILTER_BREAK = 1, valid byte E0: no strobe, no state change.
REQ-023 With FILTER_BREAK = 1, a valid byte while break_pending: no strobe, ps2_info unchanged, break_pending cleared.
REQ-024 With FILTER_BREAK = 0, every valid byte is strobed.
REQ-025 Invalid frames do not alter break_pending.
REQ-026 Timeout counter clears on every falling edge and increments otherwise while not IDLE.
REQ-027 When the timeout counter reaches TIMEOUT-1 outside IDLE: -> IDLE, frame_error pulse, shift and bit count cleared.
REQ-028 ps2_enable and frame_error never assert in the same cycle.
REQ-029 ps2_enable and frame_error never assert on consecutive cycles from one frame.

Reset
REQ-030 While reset = 0, asynchronously: state IDLE, ps2_info 8'h00, ps2_enable 0, frame_error 0, busy 0, break_pending 0, counters 0, sync/previous registers 1 (idle-high line).
REQ-031 Reset mid-frame discards the partial frame with no strobe.
REQ-032 After reset deasserts, the next start bit begins a fresh frame.

Verification
REQ-033 PS/2 clock with a 40-cycle half-period, sending 0x1C with parity 0 and stop 1 -> ps2_info = 8'h1C, one ps2_enable pulse, frame_error stays 0.
REQ-034 Send 0x21 with parity 1, then 0x22 with parity 1 -> two ps2_enable pulses, ps2_info 21 then 22.
REQ-035 With FILTER_BREAK = 1, send F0 then 1C -> no ps2_enable, ps2_info retains its prior value; a following 1C -> pulse with 1C.
REQ-036 Send 0x1C with parity 1, and separately 0x1C with stop 0 -> frame_error pulse for each, no ps2_enable, ps2_info unchanged.
REQ-037 With TIMEOUT = 200, send start plus 4 bits then hold ps2_clk high for 200 cycles -> frame_error pulse, busy falls; a subsequent 0x21 frame decodes correctly.
REQ-038 Assert reset low after 6 bits of a frame, then release -> all outputs at reset values, no strobe; the next full 0x1C frame decodes.
